// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-requester Memory Unit arbiter.
package mem_arbiter_pkg;

  localparam int unsigned AddrWDefault   = 27;
  localparam int unsigned DataWDefault   = 32;
  localparam int unsigned TimeoutDefault = 15;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StAck
  } state_e;

  // Watchdog counter must be able to hold the value TIMEOUT itself.
  function automatic int unsigned wdog_cnt_w(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, response and Memory Unit signals of the arbiter, bundled with master/slave views.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) ();

  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              we0;
  logic              ack0;

  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              we1;
  logic              ack1;

  logic [DATA_W-1:0] q;
  logic              err;

  logic [ADDR_W-1:0] mu_address;
  logic [DATA_W-1:0] mu_data;
  logic              mu_we;
  logic              mu_start;
  logic              mu_initDone;
  logic              mu_busy;
  logic [DATA_W-1:0] mu_q;

  // Arbiter side.
  modport slave (
    input  req0, addr0, data0, we0, req1, addr1, data1, we1,
    input  mu_initDone, mu_busy, mu_q,
    output ack0, ack1, q, err, mu_address, mu_data, mu_we, mu_start
  );

  // Requesters plus Memory Unit side.
  modport master (
    output req0, addr0, data0, we0, req1, addr1, data1, we1,
    output mu_initDone, mu_busy, mu_q,
    input  ack0, ack1, q, err, mu_address, mu_data, mu_we, mu_start
  );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick; the pointer register lives in the caller.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_id_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    case (req_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin front end sequencing start/busy transactions to the Memory Unit,
// with a watchdog that aborts when busy never rises.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = AddrWDefault,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input logic          clk,
  input logic          nreset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CntW = wdog_cnt_w(TIMEOUT);

  state_e            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;  // requester favoured when both request
  logic              gnt_q, gnt_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              we_q, we_d;
  logic              start_q, start_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic pick_id;
  logic pick_any;

  rr_arbiter2 u_rr (
    .req_i        ({bus.req1, bus.req0}),
    .last_grant_i (~rr_ptr_q),
    .grant_id_o   (pick_id),
    .any_o        (pick_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = we_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    start_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;

    case (state_q)
      StIdle: begin
        // busy must be low so an operation aborted by reset drains first
        if (bus.mu_initDone && !bus.mu_busy && pick_any) begin
          gnt_d   = pick_id;
          addr_d  = pick_id ? bus.addr1 : bus.addr0;
          data_d  = pick_id ? bus.data1 : bus.data0;
          we_d    = pick_id ? bus.we1   : bus.we0;
          start_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.mu_busy) begin
          state_d = StWaitDone;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          err_d   = 1'b1;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitDone: begin
        if (!bus.mu_busy) begin
          rdata_d = bus.mu_q;
          err_d   = 1'b0;
          ack0_d  = ~gnt_q;
          ack1_d  = gnt_q;
          state_d = StAck;
        end
      end
      StAck: begin
        rr_ptr_d = ~gnt_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= StIdle;
      rr_ptr_q <= 1'b0;
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      start_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      start_q  <= start_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.q          = rdata_q;
  assign bus.err        = err_q;
  assign bus.mu_address = addr_q;
  assign bus.mu_data    = data_q;
  assign bus.mu_we      = we_q;
  assign bus.mu_start   = start_q;

endmodule
